// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin arbiter sharing one data-memory port between
// the CPU load/store path (port 0) and the debug/loader path (port 1).
//
// Ports:
//   clk, reset          - rising-edge clock, async active-high reset
//   reqN/lockN/weN      - request, burst lock, write enable per port
//   addrN/wdataN        - access address and write data per port
//   gntN                - access performed this cycle for port N
//   rvalidN/rdata       - registered read data with per-port valid pulse
//   mem_*               - drive to / read data from data_memory
//   conflict_cnt        - saturating count of contended cycles
//
// Optional: define DMEM_ARB_CONFLICT_CNT_EN to build the conflict counter;
// otherwise conflict_cnt is tied to zero.
module dmem_arbiter #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 8,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic              lock0,
  input  logic              lock1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [7:0]        conflict_cnt
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_OWN0 = 2'd1,
    S_OWN1 = 2'd2
  } state_t;

  localparam logic [3:0] LP_BMAX = 4'(MAX_BURST - 1);

  state_t            r_state;
  logic              r_last;
  logic [3:0]        r_burst;
  logic [DATA_W-1:0] r_rdata;
  logic              r_rvalid0;
  logic              r_rvalid1;

  logic w_hold0;
  logic w_hold1;
  logic w_pick0;
  logic w_rd0;
  logic w_rd1;

  assign gnt0 = (r_state == S_OWN0);
  assign gnt1 = (r_state == S_OWN1);

  // Lock only holds the grant while the burst budget lasts.
  assign w_hold0 = req0 & lock0 & (r_burst < LP_BMAX);
  assign w_hold1 = req1 & lock1 & (r_burst < LP_BMAX);

  // From idle, port 0 wins unless only port 1 asks or port 0 won last.
  assign w_pick0 = req0 & (~req1 | r_last);

  assign w_rd0 = gnt0 & ~we0;
  assign w_rd1 = gnt1 & ~we1;

  always_comb begin
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    unique case (1'b1)
      gnt0: begin
        mem_read  = ~we0;
        mem_write = we0;
        mem_addr  = addr0;
        mem_wdata = wdata0;
      end
      gnt1: begin
        mem_read  = ~we1;
        mem_write = we1;
        mem_addr  = addr1;
        mem_wdata = wdata1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_last    <= 1'b1;
      r_burst   <= '0;
      r_rdata   <= '0;
      r_rvalid0 <= 1'b0;
      r_rvalid1 <= 1'b0;
    end else begin
      r_rvalid0 <= w_rd0;
      r_rvalid1 <= w_rd1;
      if (w_rd0 | w_rd1) r_rdata <= mem_rdata;
      unique case (r_state)
        S_IDLE: begin
          r_burst <= '0;
          if (w_pick0) begin
            r_state <= S_OWN0;
            r_last  <= 1'b0;
          end else if (req1) begin
            r_state <= S_OWN1;
            r_last  <= 1'b1;
          end
        end
        S_OWN0: begin
          if (req1 & ~w_hold0) begin
            r_state <= S_OWN1;
            r_last  <= 1'b1;
            r_burst <= '0;
          end else if (req0) begin
            if (r_burst != LP_BMAX) r_burst <= r_burst + 4'd1;
          end else begin
            r_state <= S_IDLE;
            r_burst <= '0;
          end
        end
        S_OWN1: begin
          if (req0 & ~w_hold1) begin
            r_state <= S_OWN0;
            r_last  <= 1'b0;
            r_burst <= '0;
          end else if (req1) begin
            if (r_burst != LP_BMAX) r_burst <= r_burst + 4'd1;
          end else begin
            r_state <= S_IDLE;
            r_burst <= '0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_burst <= '0;
        end
      endcase
    end
  end

  assign rdata   = r_rdata;
  assign rvalid0 = r_rvalid0;
  assign rvalid1 = r_rvalid1;

`ifdef DMEM_ARB_CONFLICT_CNT_EN
  logic [7:0] r_conf;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_conf <= '0;
    end else if (req0 & req1 & (r_conf != 8'hFF)) begin
      r_conf <= r_conf + 8'd1;
    end
  end

  assign conflict_cnt = r_conf;
`else
  assign conflict_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Testbench for dmem_arbiter: directed stimulus, queued expectations,
// independent monitor comparing grants and read returns.
module tb_dmem_arbiter;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       req0 = 0, req1 = 0, lock0 = 0, lock1 = 0;
  logic       we0 = 0, we1 = 0;
  logic [7:0] addr0 = 0, addr1 = 0, wdata0 = 0, wdata1 = 0;
  logic       gnt0, gnt1, rvalid0, rvalid1;
  logic [7:0] rdata;
  logic       mem_read, mem_write;
  logic [7:0] mem_addr, mem_wdata, mem_rdata;
  logic [7:0] conflict_cnt;

  logic [7:0] mem [256];

  always #5 clk = ~clk;

  dmem_arbiter #(
    .DATA_W(8), .ADDR_W(8), .MAX_BURST(4)
  ) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1),
    .lock0(lock0), .lock1(lock1),
    .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1),
    .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1),
    .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata(rdata),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .conflict_cnt(conflict_cnt)
  );

  assign mem_rdata = mem[mem_addr];

  always @(posedge clk) begin
    if (mem_write) mem[mem_addr] <= mem_wdata;
  end

  typedef struct packed {
    logic       port;
    logic [7:0] addr;
    logic       we;
    logic [7:0] wd;
  } gexp_t;

  typedef struct packed {
    logic       port;
    logic [7:0] data;
  } rexp_t;

  gexp_t gq[$];
  rexp_t rq[$];
  gexp_t mg;
  rexp_t mr;
  int    total = 0;
  int    bad = 0;

`ifdef DMEM_ARB_CONFLICT_CNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  task automatic chk(input string nm, input int unsigned act,
                     input int unsigned exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", nm, act, exp);
    end
  endtask

  function automatic int unsigned cexp(input int unsigned n);
    if (!CNT_ON) return 0;
    return (n > 255) ? 255 : n;
  endfunction

  // Monitor: pops an expectation whenever the DUT shows a grant or a read.
  always @(negedge clk) begin
    if (!reset) begin
      chk("gnt_excl", 32'(gnt0 & gnt1), 0);
      if (gnt0 | gnt1) begin
        if (gq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL gnt_unexpected: got port=%0d want none", gnt1);
        end else begin
          mg = gq.pop_front();
          chk("gnt_port", 32'(gnt1), 32'(mg.port));
          chk("mem_addr", 32'(mem_addr), 32'(mg.addr));
          chk("mem_write", 32'(mem_write), 32'(mg.we));
          chk("mem_read", 32'(mem_read), 32'(!mg.we));
          if (mg.we) chk("mem_wdata", 32'(mem_wdata), 32'(mg.wd));
        end
      end else begin
        chk("idle_mem", 32'({mem_read, mem_write, mem_addr, mem_wdata}), 0);
      end
      if (rvalid0 | rvalid1) begin
        chk("rv_excl", 32'(rvalid0 & rvalid1), 0);
        if (rq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL rvalid_unexpected: got port=%0d want none", rvalid1);
        end else begin
          mr = rq.pop_front();
          chk("rv_port", 32'(rvalid1), 32'(mr.port));
          chk("rdata", 32'(rdata), 32'(mr.data));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drop_all();
    req0 = 0; req1 = 0; lock0 = 0; lock1 = 0;
  endtask

  task automatic do_reset();
    drop_all();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic set_port(input bit p, input bit rq_, input bit lk,
                          input bit w, input [7:0] a, input [7:0] d);
    if (p) begin
      req1 = rq_; lock1 = lk; we1 = w; addr1 = a; wdata1 = d;
    end else begin
      req0 = rq_; lock0 = lk; we0 = w; addr0 = a; wdata0 = d;
    end
  endtask

  // One access; requester drops req as soon as it sees its grant.
  task automatic access(input bit p, input bit w, input [7:0] a,
                        input [7:0] d, input [7:0] exp_rd,
                        output int lat);
    bit got;
    gq.push_back('{p, a, w, d});
    if (!w) rq.push_back('{p, exp_rd});
    set_port(p, 1'b1, 1'b0, w, a, d);
    lat = 0;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      tick();
      lat++;
      got = p ? gnt1 : gnt0;
    end
    total++;
    if (!got) begin
      bad++;
      $display("FAIL grant_timeout: port=%0d got none want gnt", p);
    end
    set_port(p, 1'b0, 1'b0, w, a, d);
    tick();
    tick();
  endtask

  initial begin
    int lat;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h10] = 8'hA5;
    mem[8'h20] = 8'h11;
    mem[8'h21] = 8'h22;
    mem[8'h31] = 8'h77;
    mem[8'h41] = 8'h99;

    // Reset state while reset is held.
    #7;
    chk("rst_gnt", 32'({gnt0, gnt1}), 0);
    chk("rst_rvalid", 32'({rvalid0, rvalid1}), 0);
    chk("rst_rdata", 32'(rdata), 0);
    chk("rst_mem", 32'({mem_read, mem_write, mem_addr, mem_wdata}), 0);
    chk("rst_conf", 32'(conflict_cnt), 0);
    tick();
    reset = 1'b0;
    tick();

    // Single read, port 0.
    access(1'b0, 1'b0, 8'h10, 8'h00, 8'hA5, lat);
    chk("read_latency", 32'(lat), 1);

    // Simultaneous requests: 0,1,0,1.
    do_reset();
    gq.push_back('{1'b0, 8'h20, 1'b0, 8'h00});
    gq.push_back('{1'b1, 8'h21, 1'b0, 8'h00});
    gq.push_back('{1'b0, 8'h20, 1'b0, 8'h00});
    gq.push_back('{1'b1, 8'h21, 1'b0, 8'h00});
    rq.push_back('{1'b0, 8'h11});
    rq.push_back('{1'b1, 8'h22});
    rq.push_back('{1'b0, 8'h11});
    rq.push_back('{1'b1, 8'h22});
    set_port(1'b0, 1'b1, 1'b0, 1'b0, 8'h20, 8'h00);
    set_port(1'b1, 1'b1, 1'b0, 1'b0, 8'h21, 8'h00);
    repeat (4) tick();
    drop_all();
    repeat (3) tick();
    chk("conf_rr", 32'(conflict_cnt), cexp(4));

    // Burst limit: locked port 0 gets 4, then port 1 gets 1.
    do_reset();
    repeat (4) gq.push_back('{1'b0, 8'h30, 1'b1, 8'h5A});
    gq.push_back('{1'b1, 8'h31, 1'b0, 8'h00});
    gq.push_back('{1'b0, 8'h30, 1'b1, 8'h5A});
    rq.push_back('{1'b1, 8'h77});
    set_port(1'b0, 1'b1, 1'b1, 1'b1, 8'h30, 8'h5A);
    set_port(1'b1, 1'b1, 1'b0, 1'b0, 8'h31, 8'h00);
    repeat (6) tick();
    drop_all();
    repeat (3) tick();
    chk("conf_burst", 32'(conflict_cnt), cexp(6));
    chk("burst_wr_mem", 32'(mem[8'h30]), 32'h5A);

    // Locked owner alone 20 cycles; burst count must not wrap.
    do_reset();
    repeat (20) gq.push_back('{1'b0, 8'h40, 1'b1, 8'h01});
    gq.push_back('{1'b1, 8'h41, 1'b0, 8'h00});
    rq.push_back('{1'b1, 8'h99});
    set_port(1'b0, 1'b1, 1'b1, 1'b1, 8'h40, 8'h01);
    repeat (20) tick();
    set_port(1'b1, 1'b1, 1'b0, 1'b0, 8'h41, 8'h00);
    tick();
    chk("sat_switch", 32'({gnt1, gnt0}), 32'b10);
    drop_all();
    repeat (3) tick();

    // Port 1 write then read back.
    access(1'b1, 1'b1, 8'h07, 8'h3C, 8'h00, lat);
    access(1'b1, 1'b0, 8'h07, 8'h00, 8'h3C, lat);
    chk("rd_latency1", 32'(lat), 1);

    // Reset in the middle of a port 0 write grant.
    do_reset();
    set_port(1'b0, 1'b1, 1'b0, 1'b1, 8'h70, 8'hEE);
    tick();
    chk("pre_rst_gnt0", 32'(gnt0), 1);
    chk("pre_rst_wr", 32'(mem_write), 1);
    #1 reset = 1'b1;
    #1;
    chk("mid_rst_gnt0", 32'(gnt0), 0);
    chk("mid_rst_wr", 32'(mem_write), 0);
    chk("mid_rst_rv", 32'(rvalid0), 0);
    drop_all();
    tick();
    tick();
    reset = 1'b0;
    tick();
    chk("post_rst_gnt", 32'({gnt0, gnt1}), 0);
    chk("post_rst_mem", 32'({mem_read, mem_write}), 0);
    chk("post_rst_conf", 32'(conflict_cnt), 0);
    chk("no_write_70", 32'(mem[8'h70]), 0);

    // 300 contended cycles: counter saturates (or stays 0).
    do_reset();
    for (int i = 0; i < 300; i++) begin
      if (i % 2 == 0) gq.push_back('{1'b0, 8'h60, 1'b1, 8'hB0});
      else            gq.push_back('{1'b1, 8'h61, 1'b1, 8'hB1});
    end
    set_port(1'b0, 1'b1, 1'b0, 1'b1, 8'h60, 8'hB0);
    set_port(1'b1, 1'b1, 1'b0, 1'b1, 8'h61, 8'hB1);
    repeat (300) tick();
    drop_all();
    repeat (3) tick();
    chk("conf_sat", 32'(conflict_cnt), cexp(300));

    chk("gq_empty", 32'(gq.size()), 0);
    chk("rq_empty", 32'(rq.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

endmodule
